// File: rtl/micro_sequencer.sv
// Microcode sequencer: holds the current opcode and microstep that address the microcode ROM.
// Handles halts, conditional micro-branches, interrupt entry and a stall watchdog.
module micro_sequencer #(
   parameter int UADDR_W   = 6,
   parameter int OPC_W     = 6,
   parameter int NUM_HALT  = 6,
   parameter int NUM_COND  = 4,
   parameter int FETCH_OPC = 0,
   parameter int IRQ_OPC   = 63,
   parameter int WDOG_W    = 16,
   parameter int SEL_W     = (NUM_COND > 1) ? $clog2(NUM_COND) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPC_W-1:0]    instr_in,
   input  logic                ucode_end,
   input  logic                ucode_branch,
   input  logic [SEL_W-1:0]    branch_sel,
   input  logic [UADDR_W-1:0]  branch_target,
   input  logic [NUM_COND-1:0] cond,
   input  logic [NUM_HALT-1:0] halt_en,
   input  logic [NUM_HALT-1:0] halt_busy,
   input  logic                hard_halt,
   input  logic                irq,
   input  logic                irq_en,
   input  logic [WDOG_W-1:0]   wdog_limit,
   output logic [OPC_W-1:0]    opcode,
   output logic [UADDR_W-1:0]  uaddr,
   output logic                stalled,
   output logic                irq_ack,
   output logic                wdog_timeout,
   output logic                uaddr_overflow
);

   logic [OPC_W-1:0]   opcode_q, opcode_d;
   logic [UADDR_W-1:0] uaddr_q, uaddr_d;
   logic               irq_ack_q, irq_ack_d;
   logic               irq_pending_q, irq_pending_d;
   logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
   logic               wdog_timeout_q, wdog_timeout_d;
   logic               overflow_q, overflow_d;

   logic               soft_wait_s;
   logic               stalled_s;
   logic               cond_hit_s;
   logic [WDOG_W-1:0]  wdog_inc_s;

   // Stall qualification and branch condition select; out-of-range selects read as false
   always_comb begin
      soft_wait_s = (|(halt_en & halt_busy)) & ~wdog_timeout_q;
      stalled_s   = hard_halt | soft_wait_s;
      wdog_inc_s  = wdog_cnt_q + WDOG_W'(1);
      cond_hit_s  = 1'b0;
      for (int i = 0; i < NUM_COND; i++) begin
         if (branch_sel == SEL_W'(i)) begin
            cond_hit_s = cond[i];
         end else begin
            cond_hit_s = cond_hit_s;
         end
      end
   end

   // Next-state for opcode/microstep sequencing, IRQ entry and watchdog
   always_comb begin
      opcode_d       = opcode_q;
      uaddr_d        = uaddr_q;
      irq_ack_d      = 1'b0;
      irq_pending_d  = irq_pending_q | irq;
      wdog_cnt_d     = wdog_cnt_q;
      wdog_timeout_d = wdog_timeout_q;
      overflow_d     = overflow_q;

      if (!stalled_s) begin
         if (ucode_end) begin
            uaddr_d        = '0;
            wdog_timeout_d = 1'b0;
            if (opcode_q != OPC_W'(FETCH_OPC)) begin
               opcode_d = OPC_W'(FETCH_OPC);
            end else if (irq_pending_q && irq_en && (opcode_q != OPC_W'(IRQ_OPC))) begin
               opcode_d      = OPC_W'(IRQ_OPC);
               irq_ack_d     = 1'b1;
               // A request arriving on the acknowledge edge stays pending
               irq_pending_d = irq;
            end else begin
               opcode_d = instr_in;
            end
         end else if (ucode_branch && cond_hit_s) begin
            uaddr_d = branch_target;
         end else begin
            uaddr_d = uaddr_q + UADDR_W'(1);
            if (uaddr_q == '1) begin
               overflow_d = 1'b1;
            end else begin
               overflow_d = overflow_q;
            end
         end
      end else begin
         opcode_d = opcode_q;
         uaddr_d  = uaddr_q;
      end

      // Only soft waits age the watchdog; a hard halt freezes the count
      if ((wdog_limit == '0) || !stalled_s) begin
         wdog_cnt_d = '0;
      end else if (soft_wait_s && !hard_halt) begin
         wdog_cnt_d = wdog_inc_s;
         if (wdog_inc_s == wdog_limit) begin
            wdog_timeout_d = 1'b1;
         end else begin
            wdog_timeout_d = wdog_timeout_q;
         end
      end else begin
         wdog_cnt_d = wdog_cnt_q;
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q       <= OPC_W'(FETCH_OPC);
         uaddr_q        <= '0;
         irq_ack_q      <= 1'b0;
         irq_pending_q  <= 1'b0;
         wdog_cnt_q     <= '0;
         wdog_timeout_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         opcode_q       <= opcode_d;
         uaddr_q        <= uaddr_d;
         irq_ack_q      <= irq_ack_d;
         irq_pending_q  <= irq_pending_d;
         wdog_cnt_q     <= wdog_cnt_d;
         wdog_timeout_q <= wdog_timeout_d;
         overflow_q     <= overflow_d;
      end
   end

   assign opcode         = opcode_q;
   assign uaddr          = uaddr_q;
   assign stalled        = stalled_s;
   assign irq_ack        = irq_ack_q;
   assign wdog_timeout   = wdog_timeout_q;
   assign uaddr_overflow = overflow_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: expected {opcode, uaddr, irq_ack} are queued
// as stimulus is driven and compared after each clock edge.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  instr_in = 6'd0;
   logic        ucode_end = 1'b0;
   logic        ucode_branch = 1'b0;
   logic [1:0]  branch_sel = 2'd0;
   logic [5:0]  branch_target = 6'd0;
   logic [3:0]  cond = 4'd0;
   logic [5:0]  halt_en = 6'd0;
   logic [5:0]  halt_busy = 6'd0;
   logic        hard_halt = 1'b0;
   logic        irq = 1'b0;
   logic        irq_en = 1'b0;
   logic [15:0] wdog_limit = 16'd0;
   logic [5:0]  opcode;
   logic [5:0]  uaddr;
   logic        stalled;
   logic        irq_ack;
   logic        wdog_timeout;
   logic        uaddr_overflow;

   logic [12:0] exp_q[$];
   logic [12:0] exp_w;
   int total = 0;
   int bad = 0;

   micro_sequencer dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .ucode_end(ucode_end),
      .ucode_branch(ucode_branch), .branch_sel(branch_sel), .branch_target(branch_target),
      .cond(cond), .halt_en(halt_en), .halt_busy(halt_busy), .hard_halt(hard_halt),
      .irq(irq), .irq_en(irq_en), .wdog_limit(wdog_limit), .opcode(opcode), .uaddr(uaddr),
      .stalled(stalled), .irq_ack(irq_ack), .wdog_timeout(wdog_timeout),
      .uaddr_overflow(uaddr_overflow)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({opcode, uaddr, irq_ack, wdog_timeout, uaddr_overflow, stalled} !== 16'd0) begin
         bad++;
         $display("FAIL reset: got op=%0d ua=%0d ack=%0b to=%0b ovf=%0b st=%0b, want all 0",
                  opcode, uaddr, irq_ack, wdog_timeout, uaddr_overflow, stalled);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_dispatch();
      logic       ends [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [5:0] eops [7] = '{6'd0, 6'd0, 6'd0, 6'd5, 6'd5, 6'd5, 6'd0};
      logic [5:0] euas [7] = '{6'd1, 6'd2, 6'd3, 6'd0, 6'd1, 6'd2, 6'd0};
      instr_in = 6'd5;
      for (int i = 0; i < 7; i++) begin
         ucode_end = ends[i];
         exp_q.push_back({eops[i], euas[i], 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack} !== exp_w) begin
            bad++;
            $display("FAIL dispatch[%0d]: got op=%0d ua=%0d want op=%0d ua=%0d",
                     i, opcode, uaddr, exp_w[12:7], exp_w[6:1]);
         end
      end
      ucode_end = 1'b0;
   endtask

   task automatic test_halt();
      cyc();
      cyc();
      halt_en = 6'b000001;
      halt_busy = 6'b000001;
      for (int i = 0; i < 10; i++) begin
         #1;
         total++;
         if (stalled !== 1'b1) begin
            bad++;
            $display("FAIL halt_stalled[%0d]: got %0b want 1", i, stalled);
         end
         exp_q.push_back({6'd0, 6'd2, 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack} !== exp_w) begin
            bad++;
            $display("FAIL halt_hold[%0d]: got op=%0d ua=%0d want op=%0d ua=%0d",
                     i, opcode, uaddr, exp_w[12:7], exp_w[6:1]);
         end
      end
      halt_busy = 6'b000000;
      exp_q.push_back({6'd0, 6'd3, 1'b0});
      cyc();
      exp_w = exp_q.pop_front();
      total++;
      if ({opcode, uaddr, irq_ack} !== exp_w) begin
         bad++;
         $display("FAIL halt_release: got ua=%0d want ua=%0d", uaddr, exp_w[6:1]);
      end
      halt_en = 6'b000000;
   endtask

   task automatic test_branch();
      // {end, hard_halt, sel[2], cond[4], target[6], exp_op[6], exp_ua[6]}
      logic [25:0] rows [6] = '{
         {1'b0, 1'b0, 2'd1, 4'b0010, 6'd9,  6'd0, 6'd9},
         {1'b0, 1'b0, 2'd1, 4'b0000, 6'd9,  6'd0, 6'd10},
         {1'b0, 1'b0, 2'd3, 4'b1000, 6'd20, 6'd0, 6'd20},
         {1'b0, 1'b0, 2'd2, 4'b1011, 6'd9,  6'd0, 6'd21},
         {1'b0, 1'b1, 2'd1, 4'b0010, 6'd9,  6'd0, 6'd21},
         {1'b1, 1'b0, 2'd1, 4'b0010, 6'd9,  6'd5, 6'd0}};
      ucode_branch = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ucode_end     = rows[i][25];
         hard_halt     = rows[i][24];
         branch_sel    = rows[i][23:22];
         cond          = rows[i][21:18];
         branch_target = rows[i][17:12];
         exp_q.push_back({rows[i][11:0], 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack} !== exp_w) begin
            bad++;
            $display("FAIL branch[%0d]: got op=%0d ua=%0d want op=%0d ua=%0d",
                     i, opcode, uaddr, exp_w[12:7], exp_w[6:1]);
         end
      end
      ucode_branch = 1'b0;
      ucode_end = 1'b0;
      hard_halt = 1'b0;
      cond = 4'd0;
   endtask

   task automatic test_irq();
      // {end, irq, irq_en, exp_op[6], exp_ua[6], exp_ack}
      logic [15:0] rows [18] = '{
         {1'b0, 1'b1, 1'b1, 6'd5,  6'd1, 1'b0},
         {1'b0, 1'b0, 1'b1, 6'd5,  6'd2, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0},
         {1'b0, 1'b0, 1'b1, 6'd0,  6'd1, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd63, 6'd0, 1'b1},
         {1'b0, 1'b0, 1'b1, 6'd63, 6'd1, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd5,  6'd0, 1'b0},
         {1'b0, 1'b1, 1'b0, 6'd5,  6'd1, 1'b0},
         {1'b1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b0, 6'd5,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b0, 6'd0,  6'd0, 1'b0},
         {1'b1, 1'b1, 1'b1, 6'd63, 6'd0, 1'b1},
         {1'b1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd63, 6'd0, 1'b1},
         {1'b1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd5,  6'd0, 1'b0},
         {1'b1, 1'b0, 1'b1, 6'd0,  6'd0, 1'b0}};
      instr_in = 6'd5;
      for (int i = 0; i < 18; i++) begin
         ucode_end = rows[i][15];
         irq       = rows[i][14];
         irq_en    = rows[i][13];
         exp_q.push_back(rows[i][12:0]);
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack} !== exp_w) begin
            bad++;
            $display("FAIL irq[%0d]: got op=%0d ua=%0d ack=%0b want op=%0d ua=%0d ack=%0b",
                     i, opcode, uaddr, irq_ack, exp_w[12:7], exp_w[6:1], exp_w[0]);
         end
      end
      ucode_end = 1'b0;
      irq = 1'b0;
      irq_en = 1'b0;
   endtask

   task automatic test_watchdog();
      instr_in = 6'd5;
      wdog_limit = 16'd4;
      halt_en = 6'b000001;
      halt_busy = 6'b000001;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({6'd0, 6'd0, 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack, wdog_timeout} !== {exp_w, (i == 4)}) begin
            bad++;
            $display("FAIL wdog_count[%0d]: got ua=%0d to=%0b want ua=%0d to=%0b",
                     i, uaddr, wdog_timeout, exp_w[6:1], (i == 4));
         end
      end
      total++;
      if (stalled !== 1'b0) begin
         bad++;
         $display("FAIL wdog_release: stalled got %0b want 0", stalled);
      end
      for (int i = 1; i <= 2; i++) begin
         exp_q.push_back({6'd0, 6'(i), 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack, wdog_timeout} !== {exp_w, 1'b1}) begin
            bad++;
            $display("FAIL wdog_advance[%0d]: got ua=%0d to=%0b want ua=%0d to=1",
                     i, uaddr, wdog_timeout, exp_w[6:1]);
         end
      end
      ucode_end = 1'b1;
      exp_q.push_back({6'd5, 6'd0, 1'b0});
      cyc();
      ucode_end = 1'b0;
      exp_w = exp_q.pop_front();
      total++;
      if ({opcode, uaddr, irq_ack, wdog_timeout, stalled} !== {exp_w, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL wdog_clear: got op=%0d ua=%0d to=%0b st=%0b want op=5 ua=0 to=0 st=1",
                  opcode, uaddr, wdog_timeout, stalled);
      end
      hard_halt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back({6'd5, 6'd0, 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack, wdog_timeout} !== {exp_w, 1'b0}) begin
            bad++;
            $display("FAIL wdog_hard[%0d]: got ua=%0d to=%0b want ua=0 to=0", i, uaddr, wdog_timeout);
         end
      end
      hard_halt = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({6'd5, 6'd0, 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack, wdog_timeout} !== {exp_w, (i == 4)}) begin
            bad++;
            $display("FAIL wdog_after_hard[%0d]: got ua=%0d to=%0b want ua=0 to=%0b",
                     i, uaddr, wdog_timeout, (i == 4));
         end
      end
      ucode_end = 1'b1;
      halt_busy = 6'b000000;
      halt_en = 6'b000000;
      exp_q.push_back({6'd0, 6'd0, 1'b0});
      cyc();
      ucode_end = 1'b0;
      wdog_limit = 16'd0;
      exp_w = exp_q.pop_front();
      total++;
      if ({opcode, uaddr, irq_ack, wdog_timeout} !== {exp_w, 1'b0}) begin
         bad++;
         $display("FAIL wdog_final: got op=%0d ua=%0d to=%0b want op=0 ua=0 to=0",
                  opcode, uaddr, wdog_timeout);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 66; i++) begin
         exp_q.push_back({6'd0, 6'(i % 64), 1'b0});
         cyc();
         exp_w = exp_q.pop_front();
         total++;
         if ({opcode, uaddr, irq_ack, uaddr_overflow} !== {exp_w, (i >= 64)}) begin
            bad++;
            $display("FAIL overflow[%0d]: got ua=%0d ovf=%0b want ua=%0d ovf=%0b",
                     i, uaddr, uaddr_overflow, exp_w[6:1], (i >= 64));
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      instr_in = 6'd5;
      ucode_end = 1'b1;
      cyc();
      ucode_end = 1'b0;
      cyc();
      irq = 1'b1;
      cyc();
      irq = 1'b0;
      halt_en = 6'b000001;
      halt_busy = 6'b000001;
      cyc();
      cyc();
      total++;
      if ({opcode, uaddr, uaddr_overflow, stalled} !== {6'd5, 6'd2, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL pre_reset: got op=%0d ua=%0d ovf=%0b st=%0b want op=5 ua=2 ovf=1 st=1",
                  opcode, uaddr, uaddr_overflow, stalled);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({opcode, uaddr, irq_ack, wdog_timeout, uaddr_overflow} !== 15'd0) begin
         bad++;
         $display("FAIL reset_mid_stall: got op=%0d ua=%0d ack=%0b to=%0b ovf=%0b want all 0",
                  opcode, uaddr, irq_ack, wdog_timeout, uaddr_overflow);
      end
      @(negedge clk);
      reset = 1'b0;
      halt_en = 6'b000000;
      halt_busy = 6'b000000;
      ucode_end = 1'b1;
      irq_en = 1'b1;
      exp_q.push_back({6'd5, 6'd0, 1'b0});
      cyc();
      ucode_end = 1'b0;
      irq_en = 1'b0;
      exp_w = exp_q.pop_front();
      total++;
      if ({opcode, uaddr, irq_ack} !== exp_w) begin
         bad++;
         $display("FAIL irq_dropped: got op=%0d ack=%0b want op=%0d ack=0", opcode, irq_ack, exp_w[12:7]);
      end
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_halt();
      test_branch();
      test_irq();
      test_watchdog();
      test_overflow();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
